// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 transmitter (keyboard model) with an 8-deep scan-code FIFO.
// Serialises each byte as an 11-bit frame {stop, odd parity, data[7:0], start}, bit0 first.
// The PS/2 clock is derived from the system clock, and the host clock-inhibit is honoured.
// Ports:
//   clock, resetn          system clock, synchronous active-low reset
//   in_valid/in_data       scan-code byte offered; taken when in_valid & in_ready
//   in_ready               FIFO not full
//   ps2_clk_o/ps2_dat_o    line drive levels (1 = released)
//   ps2_clk_i              sensed PS/2 clock line (asynchronous)
//   busy                   frame or inter-frame gap in progress
//   fifo_count             bytes buffered, including the byte being sent
//   abort_pulse            one-cycle pulse when the host inhibit aborts a frame
module ps2_kbd_tx #(
    parameter int CLK_DIV  = 50,
    parameter int FIFO_AW  = 3,
    parameter int IDLE_GAP = 100
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             ps2_clk_o,
    output logic             ps2_dat_o,
    input  logic             ps2_clk_i,
    output logic             busy,
    output logic [FIFO_AW:0] fifo_count,
    output logic             abort_pulse
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = $clog2(IDLE_GAP + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_INIT = GW'(IDLE_GAP);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_q, rd_q;
    logic [FIFO_AW:0]   cnt_q;
    logic [1:0]         sync_q;
    logic               clk_s, push, pop;
    logic [7:0]         head;
    state_t             state_q, state_d;
    logic [DW-1:0]      div_q, div_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [3:0]         bit_q, bit_d;
    logic [10:0]        sh_q, sh_d;
    logic               clk_q, clk_d, dat_q, dat_d, abort_q, abort_d;

    assign clk_s       = sync_q[1];
    assign in_ready    = cnt_q != (FIFO_AW+1)'(DEPTH);
    assign push        = in_valid & in_ready;
    assign head        = mem_q[rd_q];
    assign fifo_count  = cnt_q;
    assign busy        = state_q != IDLE;
    assign ps2_clk_o   = clk_q;
    assign ps2_dat_o   = dat_q;
    assign abort_pulse = abort_q;

    always_ff @(posedge clock)
        if (push) mem_q[wr_q] <= in_data;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], ps2_clk_i};
            wr_q   <= wr_q + FIFO_AW'(push);
            rd_q   <= rd_q + FIFO_AW'(pop);
            cnt_q  <= cnt_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            div_q   <= '0;
            gap_q   <= GAP_INIT;
            bit_q   <= '0;
            sh_q    <= '1;
            clk_q   <= 1'b1;
            dat_q   <= 1'b1;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            clk_q   <= clk_d;
            dat_q   <= dat_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        clk_d   = clk_q;
        dat_d   = dat_q;
        abort_d = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!clk_s) gap_d = GAP_INIT;
                else if (gap_q != '0) gap_d = gap_q - 1'b1;
                else if (cnt_q != '0) begin
                    sh_d    = {1'b1, ~^head, head, 1'b0};
                    dat_d   = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP, HIGH: begin
                // The synchroniser lags two cycles, so the sensed line only reflects our own
                // released clock from the third high cycle onward.
                if (div_q >= DW'(2) && !clk_s) begin
                    clk_d   = 1'b1;
                    dat_d   = 1'b1;
                    abort_d = 1'b1;
                    gap_d   = GAP_INIT;
                    state_d = GAP;
                end else if (div_q == DIV_MAX) begin
                    clk_d   = 1'b0;
                    div_d   = '0;
                    state_d = LOW;
                end else div_d = div_q + 1'b1;
            end
            LOW: begin
                if (div_q == DIV_MAX) begin
                    clk_d = 1'b1;
                    div_d = '0;
                    if (bit_q == 4'd10) begin
                        dat_d   = 1'b1;
                        pop     = 1'b1;
                        gap_d   = GAP_INIT;
                        state_d = GAP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        sh_d    = sh_q >> 1;
                        dat_d   = sh_q[1];
                        state_d = HIGH;
                    end
                end else div_d = div_q + 1'b1;
            end
            GAP: begin
                if (!clk_s) gap_d = GAP_INIT;
                else if (gap_q == '0) state_d = IDLE;
                else gap_d = gap_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx: randomized and directed bench for ps2_kbd_tx, checked against a host-side frame decoder and a byte-queue model.
module tb_ps2_kbd_tx;
    localparam int CLK_DIV  = 4;
    localparam int FIFO_AW  = 3;
    localparam int IDLE_GAP = 12;
    localparam int DEPTH    = 1 << FIFO_AW;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_ready, ps2_clk_o, ps2_dat_o, ps2_clk_i, busy, abort_pulse;
    logic [FIFO_AW:0] fifo_count;
    logic             host_clk = 1'b1;

    int vectors = 0;
    int errors = 0;

    assign ps2_clk_i = host_clk & ps2_clk_o;

    ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW), .IDLE_GAP(IDLE_GAP)) dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ps2_clk_o(ps2_clk_o), .ps2_dat_o(ps2_dat_o),
        .ps2_clk_i(ps2_clk_i), .busy(busy), .fifo_count(fifo_count),
        .abort_pulse(abort_pulse)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    // Model state: host-side frame decoder plus expected byte queue and count.
    logic [7:0]  q [$];
    logic [10:0] frames [$];
    logic [10:0] sh;
    logic [7:0]  push_data;
    logic        prev_clk = 1'b1, prev_dat = 1'b1;
    bit          active = 0, rst_pend = 0, push_pend = 0, in_frame = 0, done_pend = 0;
    int          bits = 0, rel = 0, cnt_m = 0, falls = 0, aborts = 0, host_age = 100;

    always @(negedge clock) begin
        host_age = host_clk ? host_age + 1 : 0;
        if (rst_pend) begin
            q.delete();
            cnt_m = 0; bits = 0; rel = 0;
            in_frame = 0; done_pend = 0;
            chk("rst_clk", ps2_clk_o, 1);
            chk("rst_dat", ps2_dat_o, 1);
            chk("rst_busy", busy, 0);
            chk("rst_abort", abort_pulse, 0);
            chk("rst_count", fifo_count, 0);
            chk("rst_ready", in_ready, 1);
            prev_clk = 1'b1; prev_dat = 1'b1;
            active = 1;
        end else if (active) begin
            if (push_pend) begin
                cnt_m++;
                q.push_back(push_data);
            end
            if (abort_pulse) begin
                chk("abort_lines", {ps2_clk_o, ps2_dat_o}, 2'b11);
                chk("abort_in_frame", in_frame, 1);
                chk("abort_inhibited", host_age <= 4, 1);
                aborts++;
                bits = 0; in_frame = 0; done_pend = 0;
            end else begin
                if (!ps2_clk_o) chk("dat_stable_clk_low", ps2_dat_o, prev_dat);
                if (!in_frame && ps2_clk_o && prev_dat && !ps2_dat_o) begin
                    in_frame = 1;
                    chk("idle_gap", rel >= IDLE_GAP, 1);
                end
                if (prev_clk && !ps2_clk_o) begin
                    falls++;
                    chk("fall_in_frame", in_frame, 1);
                    sh[bits] = ps2_dat_o;
                    bits++;
                    if (bits == 11) begin
                        chk("frame_start", sh[0], 0);
                        chk("frame_stop", sh[10], 1);
                        chk("frame_odd_parity", ^sh[9:1], 1);
                        if (q.size() == 0) chk("frame_unexpected", 1, 0);
                        else chk("frame_data", sh[8:1], q.pop_front());
                        frames.push_back(sh);
                        bits = 0;
                        done_pend = 1;
                    end
                end
                if (!prev_clk && ps2_clk_o && done_pend) begin
                    done_pend = 0;
                    in_frame = 0;
                    cnt_m--;
                end
            end
            rel = (ps2_clk_o && ps2_dat_o) ? rel + 1 : 0;
            chk("fifo_count", fifo_count, cnt_m);
            chk("in_ready", in_ready, cnt_m < DEPTH);
            if (in_frame) chk("busy_in_frame", busy, 1);
            prev_clk = ps2_clk_o;
            prev_dat = ps2_dat_o;
        end
        rst_pend  = !resetn;
        push_pend = resetn && in_valid && (cnt_m < DEPTH);
        push_data = in_data;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nf, f0, inh;
        repeat (3) tick;
        resetn = 1'b1;
        repeat (IDLE_GAP + 5) tick;

        // Single byte: latency, frame bits and count.
        in_valid = 1'b1; in_data = 8'h1C;
        tick;
        in_valid = 1'b0;
        chk("lat_count_after_push", fifo_count, 1);
        chk("lat_dat_before_start", ps2_dat_o, 1);
        tick;
        chk("lat_dat_start", ps2_dat_o, 0);
        for (n = 0; n < 500 && frames.size() < 1; n++) tick;
        chk("t1_frame_timeout", frames.size() >= 1, 1);
        if (frames.size() >= 1) chk("t1_frame_1C", frames[0], 11'b10000111000);
        for (n = 0; n < 100 && fifo_count != 0; n++) tick;
        chk("t1_count_drained", fifo_count, 0);

        // Back-to-back bytes.
        in_valid = 1'b1; in_data = 8'hF0;
        tick;
        in_data = 8'h1C;
        tick;
        in_valid = 1'b0;
        for (n = 0; n < 1000 && frames.size() < 3; n++) tick;
        chk("t2_frames_timeout", frames.size() >= 3, 1);
        if (frames.size() >= 3) begin
            chk("t2_frame_F0", frames[1], 11'b11111100000);
            chk("t2_frame_1C", frames[2], 11'b10000111000);
            chk("t2_parity_F0", frames[1][9], 1);
            chk("t2_parity_1C", frames[2][9], 0);
        end
        for (n = 0; n < 200 && busy; n++) tick;

        // Fill while the host inhibits; ninth byte rejected.
        host_clk = 1'b0;
        repeat (3) tick;
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 8'hA0 + 8'(i);
            tick;
        end
        in_valid = 1'b0;
        chk("t3_count_full", fifo_count, 8);
        chk("t3_ready_full", in_ready, 0);
        chk("t3_no_tx_while_inhibited", frames.size(), 3);
        host_clk = 1'b1;
        for (n = 0; n < 3000 && frames.size() < 11; n++) tick;
        chk("t3_frames_timeout", frames.size() >= 11, 1);
        for (int i = 0; i < 8; i++)
            if (frames.size() > 3 + i) chk("t3_order", frames[3 + i][8:1], 8'hA0 + 8'(i));
        for (n = 0; n < 200 && busy; n++) tick;

        // Abort in the bit-5 high phase, then a whole resend.
        nf = frames.size();
        in_valid = 1'b1; in_data = 8'h1C;
        tick;
        in_valid = 1'b0;
        for (n = 0; n < 500 && !(bits == 5 && ps2_clk_o); n++) tick;
        chk("t4_reach_bit5", bits == 5 && ps2_clk_o, 1);
        host_clk = 1'b0;
        for (n = 0; n < 20 && !abort_pulse; n++) tick;
        chk("t4_abort_pulse", abort_pulse, 1);
        chk("t4_lines_released", {ps2_clk_o, ps2_dat_o}, 2'b11);
        repeat (5) tick;
        host_clk = 1'b1;
        for (n = 0; n < 500 && frames.size() < nf + 1; n++) tick;
        chk("t4_resend_timeout", frames.size(), nf + 1);
        if (frames.size() > nf) chk("t4_resent_1C", frames[nf], 11'b10000111000);
        chk("t4_abort_count", aborts, 1);
        for (n = 0; n < 200 && busy; n++) tick;

        // Reset at bit 3.
        in_valid = 1'b1; in_data = 8'h55;
        tick;
        in_valid = 1'b0;
        for (n = 0; n < 500 && bits != 3; n++) tick;
        chk("t5_reach_bit3", bits, 3);
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        chk("t5_clk_high", ps2_clk_o, 1);
        chk("t5_dat_high", ps2_dat_o, 1);
        chk("t5_count_zero", fifo_count, 0);
        f0 = falls;
        repeat (100) tick;
        chk("t5_no_edges", falls, f0);

        // Random traffic with random host inhibits.
        inh = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_data = 8'($urandom);
            if (inh > 0) begin
                inh--;
                if (inh == 0) host_clk = 1'b1;
            end else if ($urandom_range(0, 80) == 0) begin
                inh = $urandom_range(1, 30);
                host_clk = 1'b0;
            end
            tick;
        end
        in_valid = 1'b0;
        host_clk = 1'b1;
        for (n = 0; n < 8000 && (q.size() != 0 || cnt_m != 0 || busy); n++) tick;
        chk("rand_drained", q.size() == 0 && cnt_m == 0 && !busy, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
